// File: rtl/vco_freq_meter_if.sv
// vco_freq_meter_if: measurement request/result bundle between the VCO frequency meter and its user
`timescale 1ns/1ps
interface vco_freq_meter_if #(parameter int CNT_W = 16);
  logic             vco_clk;
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;
  modport master (output vco_clk, start, input busy, done, count, overflow);
  modport slave  (input vco_clk, start, output busy, done, count, overflow);
endinterface

// File: rtl/vco_freq_meter.sv
// vco_freq_meter: counts synchronised vco_clk rising edges over a fixed clk gate window
`timescale 1ns/1ps
module vco_freq_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input logic            clk,
  input logic            rst,
  vco_freq_meter_if.slave s
);
  localparam int GW = $clog2(GATE_CYCLES);
  typedef enum logic {IDLE, GATE} state_t;
  state_t           r_state;
  logic             r_s1, r_s2, r_s3;
  logic [GW-1:0]    r_gate;
  logic [CNT_W-1:0] r_cnt, r_count, w_cnt_nxt;
  logic             r_ovf, r_overflow, r_busy, r_done;
  logic             w_edge, w_ovf_nxt;
  assign w_edge    = r_s2 & ~r_s3;
  // saturate at all-ones and remember that an edge was lost
  assign w_cnt_nxt = (w_edge && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
  assign w_ovf_nxt = r_ovf | (w_edge & (&r_cnt));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_gate     <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_s1   <= s.vco_clk;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (s.start) begin
          r_state <= GATE;
          r_busy  <= 1'b1;
          r_gate  <= GW'(GATE_CYCLES - 1);
          r_cnt   <= '0;
          r_ovf   <= 1'b0;
        end
      end else begin
        r_cnt  <= w_cnt_nxt;
        r_ovf  <= w_ovf_nxt;
        r_gate <= r_gate - 1'b1;
        if (r_gate == '0) begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_count    <= w_cnt_nxt;
          r_overflow <= w_ovf_nxt;
        end
      end
    end
  end
  assign s.busy     = r_busy;
  assign s.done     = r_done;
  assign s.count    = r_count;
  assign s.overflow = r_overflow;
endmodule

// File: tb/tb_vco_freq_meter.sv
// tb_vco_freq_meter: directed checks of gate timing, counting, saturation and reset on two meter instances
`timescale 1ns/1ps
module tb_vco_freq_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic osc_a = 1'b0, osc_b = 1'b0, vco_man = 1'b0;
  int   vh_a = 0, vh_b = 0, ph_a = 0, ph_b = 0;
  int   n_vec = 0, n_err = 0;
  int   bn, da;
  vco_freq_meter_if #(.CNT_W(16)) ma ();
  vco_freq_meter_if #(.CNT_W(4))  mb ();
  assign ma.vco_clk = (vh_a == 0) ? vco_man : osc_a;
  assign ma.start   = start_a;
  assign mb.vco_clk = osc_b;
  assign mb.start   = start_b;
  vco_freq_meter #(.GATE_CYCLES(1000), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .s(ma));
  vco_freq_meter #(.GATE_CYCLES(100),  .CNT_W(4))  u_b (.clk(clk), .rst(rst), .s(mb));
  always #5 clk = ~clk;
  // oscillators tick on a 5 ns grid offset from clk edges; vh_* is the half period (0 = stopped)
  initial begin
    #2;
    forever begin
      #5;
      if (vh_a == 0) ph_a = 0;
      else begin
        ph_a += 5;
        if (ph_a >= vh_a) begin ph_a = 0; osc_a = ~osc_a; end
      end
    end
  end
  initial begin
    #2;
    forever begin
      #5;
      if (vh_b == 0) ph_b = 0;
      else begin
        ph_b += 5;
        if (ph_b >= vh_b) begin ph_b = 0; osc_b = ~osc_b; end
      end
    end
  end
  task automatic chk(input string tag, input int got, input int exp, input int tol);
    n_vec++;
    if (got < exp - tol || got > exp + tol) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, got, exp, tol);
    end
  endtask
  task automatic kick(input bit sel);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
  endtask
  // k counts the clk edge following each negedge sample; edge 0 is the one that samples start
  task automatic track(input bit sel, input int budget, input int poke_at, input int rise_at,
                       input bit chain, output int busy_n, output int done_at);
    busy_n  = 0;
    done_at = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (sel) start_b = (k == poke_at); else start_a = (k == poke_at);
      if (k == rise_at) vco_man = 1'b1;
      if (sel ? mb.busy : ma.busy) busy_n++;
      if (sel ? mb.done : ma.done) begin
        done_at = k;
        if (sel) start_b = chain; else start_a = chain;
        break;
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(ma.busy), 0, 0);
    chk("rst_done", int'(ma.done), 0, 0);
    chk("rst_count", int'(ma.count), 0, 0);
    chk("rst_ovf", int'(ma.overflow), 0, 0);
    rst = 1'b0;
    vh_a = 50;
    repeat (20) @(negedge clk);
    kick(0);
    track(0, 1100, 0, 0, 1, bn, da);
    vh_a = 25;
    chk("nom_busy_cycles", bn, 1000, 0);
    chk("nom_done_at", da, 1001, 0);
    chk("nom_count", int'(ma.count), 100, 1);
    chk("nom_ovf", int'(ma.overflow), 0, 0);
    track(0, 1100, 0, 0, 0, bn, da);
    chk("trk_busy_cycles", bn, 1000, 0);
    chk("trk_done_at", da, 1001, 0);
    chk("trk_count", int'(ma.count), 200, 1);
    vh_a = 50;
    repeat (5) @(negedge clk);
    kick(0);
    track(0, 500, 0, 0, 0, bn, da);
    chk("mid_no_done_yet", da, 0, 0);
    chk("mid_busy_before", int'(ma.busy), 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_busy", int'(ma.busy), 0, 0);
    chk("mid_done", int'(ma.done), 0, 0);
    chk("mid_count", int'(ma.count), 0, 0);
    chk("mid_ovf", int'(ma.overflow), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_still_idle", int'(ma.busy) + int'(ma.done), 0, 0);
    kick(0);
    track(0, 1100, 0, 0, 0, bn, da);
    chk("post_rst_done_at", da, 1001, 0);
    chk("post_rst_count", int'(ma.count), 100, 1);
    vh_b = 20;
    repeat (5) @(negedge clk);
    kick(1);
    track(1, 200, 0, 0, 0, bn, da);
    chk("sat_busy_cycles", bn, 100, 0);
    chk("sat_done_at", da, 101, 0);
    chk("sat_count", int'(mb.count), 15, 0);
    chk("sat_ovf", int'(mb.overflow), 1, 0);
    vh_b = 100;
    repeat (5) @(negedge clk);
    kick(1);
    track(1, 200, 0, 0, 0, bn, da);
    chk("slow_count", int'(mb.count), 5, 1);
    chk("slow_ovf", int'(mb.overflow), 0, 0);
    vh_a = 0;
    vco_man = 1'b0;
    repeat (10) @(negedge clk);
    kick(0);
    track(0, 1100, 51, 0, 0, bn, da);
    chk("ign_busy_cycles", bn, 1000, 0);
    chk("ign_done_at", da, 1001, 0);
    chk("static_count", int'(ma.count), 0, 0);
    repeat (3) @(negedge clk);
    chk("ign_no_restart", int'(ma.busy), 0, 0);
    kick(0);
    track(0, 1100, 0, 998, 0, bn, da);
    chk("last_edge_in", int'(ma.count), 1, 0);
    vco_man = 1'b0;
    repeat (10) @(negedge clk);
    kick(0);
    track(0, 1100, 0, 999, 0, bn, da);
    chk("late_edge_out", int'(ma.count), 0, 0);
    chk("late_done_at", da, 1001, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
